// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the three buses of the fetch unit into a single interface:
//     - instruction-memory port : imem_addr, imem_en (out), imem_data (in)
//     - redirect from execute   : redir_valid, redir_target (in)
//     - decode handshake        : if_valid, if_instr, if_pc, if_pc4 (out),
//                                 if_ready (in)
//   modport master : the fetch unit's view.
//   modport slave  : the surrounding pipeline / memory view.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data;

    logic        redir_valid;
    logic [31:0] redir_target;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_data,
        input  redir_valid,
        input  redir_target,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output if_pc4
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_data,
        output redir_valid,
        output redir_target,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  if_pc4
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage with a small FIFO fetch queue in front of decode.
//   Each cycle it reads one word from a combinational instruction memory at
//   the current PC (when the queue has room or decode is draining it), pushes
//   {pc, word} into the queue and advances the PC. J-type words can redirect
//   the PC immediately (early jump). A redirect from execute flushes the queue
//   and reloads the PC.
//
// Parameters
//   DEPTH      : queue entries, power of two, >= 2
//   RESET_PC   : word-aligned PC loaded while in reset
//   EARLY_JUMP : 1 = follow J-type (opcode 000010) targets at fetch time
//
// Ports
//   clk       : clock, rising edge
//   startin   : asynchronous active-low reset
//   bus       : fetch_unit_if.master (imem port, redirect, decode handshake)
//   q_count   : number of occupied queue entries
//   align_err : one-cycle pulse after a redirect with a misaligned target
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          EARLY_JUMP = 1'b1
) (
    input  logic                   clk,
    input  logic                   startin,
    fetch_unit_if.master           bus,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   align_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [5:0] OPC_J = 6'b000010;

    // architectural state
    logic [31:0]   pc_q,        pc_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CW-1:0] count_q,     count_d;
    logic          align_err_q, align_err_d;

    // queue storage, intentionally not reset: every read is qualified by if_valid
    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic        head_valid;
    logic        pop;
    logic        push;
    logic        is_jump;
    logic [31:0] pc_plus4;
    logic [31:0] jump_pc;
    logic [31:0] head_pc;

    // Handshake decode. A pop frees a slot in the same cycle, so a full
    // queue can still fetch while decode drains it (full-rate streaming).
    // startin gates push so imem_en is low throughout reset.
    always_comb begin
        head_valid = (count_q != '0);
        pop        = head_valid && bus.if_ready;
        push       = startin && !bus.redir_valid &&
                     ((count_q != CW'(DEPTH)) || pop);
        pc_plus4   = pc_q + 32'd4;
        is_jump    = EARLY_JUMP && (bus.imem_data[31:26] == OPC_J);
        jump_pc    = {pc_plus4[31:28], bus.imem_data[25:0], 2'b00};
    end

    // Next-state logic. A redirect wins over everything else: the queue is
    // emptied, pointers return to zero and the PC reloads with the low two
    // bits dropped. A pop decode makes in the redirect cycle is still seen
    // by decode on the head outputs; only our internal copy is discarded.
    always_comb begin
        pc_d        = pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        align_err_d = bus.redir_valid && (bus.redir_target[1:0] != 2'b00);

        if (bus.redir_valid) begin
            pc_d     = {bus.redir_target[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = is_jump ? jump_pc : pc_plus4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            pc_q        <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            align_err_q <= align_err_d;
        end
    end

    // Queue storage write. push is already suppressed by reset and redirect.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= bus.imem_data;
            pc_mem[wr_ptr_q]    <= pc_q;
        end
    end

    // Outputs. The head is read straight from storage, so it cannot change
    // until the read pointer moves, which only happens on a pop.
    always_comb begin
        head_pc       = pc_mem[rd_ptr_q];
        bus.imem_addr = pc_q;
        bus.imem_en   = push;
        bus.if_valid  = head_valid;
        bus.if_instr  = instr_mem[rd_ptr_q];
        bus.if_pc     = head_pc;
        bus.if_pc4    = head_pc + 32'd4;
        q_count       = count_q;
        align_err     = align_err_q;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, sets the fetch-queue entry count; it SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the PC loaded on reset; it SHALL be word-aligned.
REQ-003 Parameter EARLY_JUMP, default 1; when 1, the block SHALL redirect fetch on J-type instructions.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 startin  input  1  reset, asynchronous, active-low.
REQ-006 imem_addr  output  32  fetch PC to the combinational instruction memory.
REQ-007 imem_en  output  1  fetch request this cycle.
REQ-008 imem_data  input  32  instruction at imem_addr, valid in the same cycle.
REQ-009 redir_valid  input  1  redirect from execute (taken branch or jr).
REQ-010 redir_target  input  32  redirect PC.
REQ-011 if_valid  output  1  queue head is valid.
REQ-012 if_ready  input  1  decode accepts the head; a pop occurs when if_valid && if_ready.
REQ-013 if_instr  output  32  instruction at the queue head.
REQ-014 if_pc  output  32  PC of the head entry.
REQ-015 if_pc4  output  32  if_pc + 4.
REQ-016 q_count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-017 align_err  output  1  one-cycle pulse when a misaligned redirect is received.

Function
REQ-018 Fetch: imem_en SHALL be 1 when there is no redirect this cycle and either q_count<DEPTH or a pop occurs this cycle.
REQ-019 On a fetch, the entry {pc, imem_data} SHALL be pushed at the tail and pc SHALL advance to pc+4, wrapping modulo 2^32.
REQ-020 Early jump: with EARLY_JUMP=1, when a fetched word has opcode [31:26]==6'b000010, pc SHALL become {(pc+4)[31:28], imem_data[25:0], 2'b00} instead of pc+4.
REQ-021 An early-jump word SHALL itself be pushed so that decode still sees it.
REQ-022 opcode 6'b000011 (jal) SHALL NOT early-jump.
REQ-023 Redirect: when redir_valid=1, the queue SHALL be flushed and q_count set to 0 at the next edge.
REQ-024 On redirect, pc SHALL load {redir_target[31:2], 2'b00}, and no push SHALL occur that cycle.
REQ-025 Redirect SHALL take priority over a simultaneous push, pop or early jump.
REQ-026 The head outputs during the redirect cycle remain valid, and a pop in that cycle SHALL still be honoured by decode; internally, state is discarded.
REQ-027 align_err SHALL pulse high in the cycle after a redirect whose redir_target[1:0] is not 0.
REQ-028 Simultaneous push and pop when full SHALL keep q_count at DEPTH and preserve order.
REQ-029 Simultaneous push and pop when empty SHALL leave the new entry at the head on the next cycle (no bypass: if_valid=0 in the push cycle).
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 The queue SHALL be FIFO-ordered.
REQ-032 if_instr, if_pc and if_pc4 SHALL be stable while if_valid=1 and if_ready=0.
REQ-033 Fetch-to-head latency SHALL be 1 cycle.
REQ-034 Steady-state throughput SHALL be 1 instruction per cycle when if_ready=1.

Reset
REQ-035 While startin=0, pc SHALL be RESET_PC, pointers 0, q_count 0, if_valid 0, align_err 0 and imem_en 0, asynchronously.
REQ-036 Deassertion of startin SHALL permit the first fetch at the next rising edge.
REQ-037 Assertion of startin mid-stream SHALL discard all entries immediately.
REQ-038 Queue data storage need not be reset; outputs SHALL be qualified by if_valid.

Verification
REQ-039 Reset release, if_ready=1, memory holding sequential non-jump words -> if_pc is 0,4,8,12 on consecutive cycles from cycle 2, and q_count stays at 1.
REQ-040 if_ready=0 for 10 cycles -> q_count saturates at 4 (DEPTH=4), imem_en=0, and the head holds PC 0.
REQ-041 Then if_ready=1 -> the entries for PCs 0,4,8,12,16 drain in order with no gap.
REQ-042 Word at 0x8 = 0x0800_0040 (j 0x100) -> next fetched PC is 0x100, and decode sees the PC sequence 0x8, then 0x100.
REQ-043 redir_valid=1, target 0x0000_0200 with the queue holding 3 entries -> q_count=0 next cycle, the next fetch is at 0x200, and no stale entry is emitted.
REQ-044 Redirect target 0x0000_0206 -> pc=0x204 and align_err pulses for one cycle.
REQ-045 startin asserted low mid-run with 2 entries queued -> if_valid falls immediately; after release, fetch restarts at RESET_PC.
